// File: rtl/punc_control.sv
// Multi-cycle FSM controller for the PUnC LC3 datapath: fetch, decode, execute
// (plus a second execute phase for LDI/STI), halting on TRAP.
module punc_control #(
  parameter logic [15:0] START_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n_flag,
  input  logic        z_flag,
  input  logic        p_flag,
  output logic        PC_ld,
  output logic        PC_clr,
  output logic        PC_inc,
  output logic        PC_data_sel,
  output logic        PC_add_sel,
  output logic        IR_ld,
  output logic [1:0]  addr_MEM_sel,
  output logic        w_en_MEM,
  output logic        store_ld,
  output logic [1:0]  w_RF_sel,
  output logic [2:0]  r_addr_0_RF,
  output logic [2:0]  r_addr_1_RF,
  output logic [2:0]  w_addr_RF,
  output logic        w_en_RF,
  output logic [1:0]  sext_sel,
  output logic        A_sel,
  output logic        B_sel,
  output logic [1:0]  ALU_sel,
  output logic        NZP_sel,
  output logic        nzp_ld,
  output logic        halted,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_op;
  logic       w_br_taken;

  assign w_op       = ir[15:12];
  assign w_br_taken = |(ir[11:9] & {n_flag, z_flag, p_flag});
  assign state_dbg  = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // NOTE: every output and the next state get a default before the case so
  // no path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_next       = r_state;
    PC_ld        = 1'b0;
    PC_clr       = 1'b0;
    PC_inc       = 1'b0;
    PC_data_sel  = 1'b0;
    PC_add_sel   = 1'b0;
    IR_ld        = 1'b0;
    addr_MEM_sel = 2'b00;
    w_en_MEM     = 1'b0;
    store_ld     = 1'b0;
    w_RF_sel     = 2'b00;
    r_addr_0_RF  = 3'b000;
    r_addr_1_RF  = 3'b000;
    w_addr_RF    = 3'b000;
    w_en_RF      = 1'b0;
    sext_sel     = 2'b00;
    A_sel        = 1'b0;
    B_sel        = 1'b0;
    ALU_sel      = 2'b00;
    NZP_sel      = 1'b0;
    nzp_ld       = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_FETCH: begin
        IR_ld  = 1'b1;
        PC_inc = 1'b1;
        w_next = S_DECODE;
      end

      S_DECODE: w_next = (w_op == OP_TRAP) ? S_HALT : S_EXEC;

      S_EXEC: begin
        w_next = S_FETCH;
        case (w_op)
          OP_ADD, OP_AND, OP_NOT: begin
            r_addr_0_RF = ir[8:6];
            A_sel       = 1'b1;
            if (ir[5]) B_sel       = 1'b1;
            else       r_addr_1_RF = ir[2:0];
            ALU_sel   = (w_op == OP_ADD) ? 2'b00 : (w_op == OP_AND) ? 2'b01 : 2'b10;
            w_RF_sel  = 2'b10;
            w_addr_RF = ir[11:9];
            w_en_RF   = 1'b1;
            nzp_ld    = 1'b1;
          end
          OP_BR: begin
            PC_ld      = w_br_taken;
            PC_add_sel = w_br_taken;
          end
          OP_JMP: begin
            r_addr_0_RF = ir[8:6];
            PC_data_sel = 1'b1;
            PC_ld       = 1'b1;
          end
          OP_JSR: begin
            w_addr_RF = 3'd7;
            w_en_RF   = 1'b1;
            PC_ld     = 1'b1;
            if (!ir[11]) begin
              PC_data_sel = 1'b1;
              r_addr_0_RF = ir[8:6];
            end
          end
          OP_LD, OP_LEA: begin
            B_sel     = 1'b1;
            sext_sel  = 2'b10;
            ALU_sel   = 2'b11;
            w_addr_RF = ir[11:9];
            w_en_RF   = 1'b1;
            nzp_ld    = 1'b1;
            if (w_op == OP_LD) begin
              addr_MEM_sel = 2'b01;
              w_RF_sel     = 2'b01;
              NZP_sel      = 1'b1;
            end else begin
              w_RF_sel     = 2'b10;
            end
          end
          OP_LDR: begin
            A_sel        = 1'b1;
            r_addr_0_RF  = ir[8:6];
            B_sel        = 1'b1;
            sext_sel     = 2'b01;
            ALU_sel      = 2'b11;
            addr_MEM_sel = 2'b01;
            w_RF_sel     = 2'b01;
            w_en_RF      = 1'b1;
            w_addr_RF    = ir[11:9];
            NZP_sel      = 1'b1;
            nzp_ld       = 1'b1;
          end
          OP_ST, OP_STR: begin
            if (w_op == OP_STR) begin
              A_sel       = 1'b1;
              r_addr_0_RF = ir[8:6];
              sext_sel    = 2'b01;
            end else begin
              sext_sel    = 2'b10;
            end
            B_sel        = 1'b1;
            ALU_sel      = 2'b11;
            addr_MEM_sel = 2'b01;
            r_addr_1_RF  = ir[11:9];
            w_en_MEM     = 1'b1;
          end
          OP_LDI, OP_STI: begin
            B_sel        = 1'b1;
            sext_sel     = 2'b10;
            ALU_sel      = 2'b11;
            addr_MEM_sel = 2'b01;
            store_ld     = 1'b1;
            w_next       = S_EXEC2;
          end
          default: ;
        endcase
      end

      S_EXEC2: begin
        w_next       = S_FETCH;
        addr_MEM_sel = 2'b10;
        if (w_op == OP_LDI) begin
          w_RF_sel  = 2'b01;
          w_en_RF   = 1'b1;
          w_addr_RF = ir[11:9];
          NZP_sel   = 1'b1;
          nzp_ld    = 1'b1;
        end else begin
          r_addr_1_RF = ir[11:9];
          w_en_MEM    = 1'b1;
        end
      end

      S_HALT: halted = 1'b1;

      default: w_next = S_FETCH;
    endcase

    // A reset cycle clears PC to START_PC and must not commit any half-done write.
    if (rst) begin
      PC_clr   = 1'b1;
      PC_ld    = 1'b0;
      PC_inc   = 1'b0;
      IR_ld    = 1'b0;
      w_en_RF  = 1'b0;
      w_en_MEM = 1'b0;
      nzp_ld   = 1'b0;
      store_ld = 1'b0;
    end
  end

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: each instruction issued pushes its expected
// per-cycle control vectors; a negedge monitor pops and compares every cycle.
module tb_punc_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        n_flag, z_flag, p_flag;
  logic        PC_ld, PC_clr, PC_inc, PC_data_sel, PC_add_sel, IR_ld;
  logic [1:0]  addr_MEM_sel;
  logic        w_en_MEM, store_ld;
  logic [1:0]  w_RF_sel;
  logic [2:0]  r_addr_0_RF, r_addr_1_RF, w_addr_RF;
  logic        w_en_RF;
  logic [1:0]  sext_sel;
  logic        A_sel, B_sel;
  logic [1:0]  ALU_sel;
  logic        NZP_sel, nzp_ld, halted;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  punc_control #(.START_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .ir(ir),
    .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag),
    .PC_ld(PC_ld), .PC_clr(PC_clr), .PC_inc(PC_inc),
    .PC_data_sel(PC_data_sel), .PC_add_sel(PC_add_sel), .IR_ld(IR_ld),
    .addr_MEM_sel(addr_MEM_sel), .w_en_MEM(w_en_MEM), .store_ld(store_ld),
    .w_RF_sel(w_RF_sel), .r_addr_0_RF(r_addr_0_RF), .r_addr_1_RF(r_addr_1_RF),
    .w_addr_RF(w_addr_RF), .w_en_RF(w_en_RF), .sext_sel(sext_sel),
    .A_sel(A_sel), .B_sel(B_sel), .ALU_sel(ALU_sel), .NZP_sel(NZP_sel),
    .nzp_ld(nzp_ld), .halted(halted), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       pc_ld, pc_clr, pc_inc, pc_data_sel, pc_add_sel, ir_ld;
    logic [1:0] addr_mem_sel;
    logic       w_en_mem, store_ld;
    logic [1:0] w_rf_sel;
    logic [2:0] ra0, ra1, wa;
    logic       w_en_rf;
    logic [1:0] sext_sel;
    logic       a_sel, b_sel;
    logic [1:0] alu_sel;
    logic       nzp_sel, nzp_ld, halted;
  } ctl_t;

  ctl_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  function automatic ctl_t idle(input logic [2:0] st);
    ctl_t c = '0;
    c.state  = st;
    c.halted = (st == 3'd4);
    return c;
  endfunction

  function automatic ctl_t fetch_vec();
    ctl_t c = idle(3'd0);
    c.ir_ld  = 1'b1;
    c.pc_inc = 1'b1;
    return c;
  endfunction

  function automatic ctl_t with_reset(input ctl_t c_in);
    ctl_t c = c_in;
    c.pc_clr   = 1'b1;
    c.pc_ld    = 1'b0;
    c.pc_inc   = 1'b0;
    c.ir_ld    = 1'b0;
    c.w_en_rf  = 1'b0;
    c.w_en_mem = 1'b0;
    c.nzp_ld   = 1'b0;
    c.store_ld = 1'b0;
    return c;
  endfunction

  // Reference: classify the instruction by what it does, then derive controls.
  function automatic ctl_t exec_model(input logic [15:0] i, input logic n, input logic z,
                                      input logic p, input bit second);
    ctl_t       c        = idle(second ? 3'd3 : 3'd2);
    logic [3:0] op       = i[15:12];
    logic [2:0] dr       = i[11:9];
    logic [2:0] sr1      = i[8:6];
    bit         alu_op   = (op == 4'd1) || (op == 4'd5) || (op == 4'd9);
    bit         pc_rel   = (op == 4'd2) || (op == 4'd3) || (op == 4'd10) || (op == 4'd11) || (op == 4'd14);
    bit         base_rel = (op == 4'd6) || (op == 4'd7);
    bit         ld_mem   = (op == 4'd2) || (op == 4'd6);
    bit         st_mem   = (op == 4'd3) || (op == 4'd7);
    bit         indirect = (op == 4'd10) || (op == 4'd11);
    if (second) begin
      c.addr_mem_sel = 2'b10;
      if (op == 4'd10) begin
        c.w_rf_sel = 2'b01; c.nzp_sel = 1'b1; c.wa = dr; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1;
      end else begin
        c.ra1 = dr; c.w_en_mem = 1'b1;
      end
      return c;
    end
    if (alu_op) begin
      c.a_sel = 1'b1; c.ra0 = sr1;
      if (i[5]) c.b_sel = 1'b1; else c.ra1 = i[2:0];
      c.alu_sel = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd2;
      c.w_rf_sel = 2'b10; c.wa = dr; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1;
    end
    if (pc_rel || base_rel) begin
      c.b_sel = 1'b1; c.alu_sel = 2'b11;
      c.sext_sel = pc_rel ? 2'b10 : 2'b01;
      if (base_rel) begin c.a_sel = 1'b1; c.ra0 = sr1; end
      if (op != 4'd14) c.addr_mem_sel = 2'b01;
    end
    if (ld_mem)   begin c.w_rf_sel = 2'b01; c.nzp_sel = 1'b1; c.wa = dr; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1; end
    if (op == 14) begin c.w_rf_sel = 2'b10; c.wa = dr; c.w_en_rf = 1'b1; c.nzp_ld = 1'b1; end
    if (st_mem)   begin c.ra1 = dr; c.w_en_mem = 1'b1; end
    if (indirect) c.store_ld = 1'b1;
    if (op == 4'd0 && ((i[11] && n) || (i[10] && z) || (i[9] && p))) begin
      c.pc_ld = 1'b1; c.pc_add_sel = 1'b1;
    end
    if (op == 4'd12) begin c.ra0 = sr1; c.pc_data_sel = 1'b1; c.pc_ld = 1'b1; end
    if (op == 4'd4) begin
      c.wa = 3'd7; c.w_en_rf = 1'b1; c.pc_ld = 1'b1; c.w_rf_sel = 2'b00;
      if (!i[11]) begin c.pc_data_sel = 1'b1; c.ra0 = sr1; end
    end
    return c;
  endfunction

  task automatic tick(input int k);
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at the start of a FETCH cycle; pushes the whole instruction's vectors.
  task automatic issue(input logic [15:0] i, input logic n, input logic z, input logic p);
    int len;
    ir = i; n_flag = n; z_flag = z; p_flag = p;
    exp_q.push_back(fetch_vec());
    exp_q.push_back(idle(3'd1));
    exp_q.push_back(exec_model(i, n, z, p, 1'b0));
    len = 3;
    if (i[15:12] == 4'd10 || i[15:12] == 4'd11) begin
      exp_q.push_back(exec_model(i, n, z, p, 1'b1));
      len = 4;
    end
    tick(len);
  endtask

  always @(negedge clk) begin
    ctl_t got, want;
    cyc++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = '{state_dbg, PC_ld, PC_clr, PC_inc, PC_data_sel, PC_add_sel, IR_ld,
              addr_MEM_sel, w_en_MEM, store_ld, w_RF_sel, r_addr_0_RF, r_addr_1_RF,
              w_addr_RF, w_en_RF, sext_sel, A_sel, B_sel, ALU_sel, NZP_sel, nzp_ld, halted};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL ctl_vec cycle %0d ir=%h: got %h required %h", cyc, ir, got, want);
      end
    end
  end

  initial begin
    rst = 1'b1; ir = 16'h0000; n_flag = 1'b0; z_flag = 1'b0; p_flag = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(with_reset(idle(3'd0)));
    exp_q.push_back(with_reset(idle(3'd0)));
    tick(2);
    rst = 1'b0;

    issue(16'h1262, 1'b0, 1'b0, 1'b0);
    issue(16'h0A05, 1'b0, 1'b1, 1'b0);
    issue(16'h0A05, 1'b1, 1'b0, 1'b0);
    issue(16'h0005, 1'b1, 1'b1, 1'b1);
    issue(16'hA403, 1'b0, 1'b0, 1'b1);
    issue(16'h4805, 1'b0, 1'b1, 1'b0);
    issue(16'h4080, 1'b0, 1'b0, 1'b0);
    issue(16'h41C0, 1'b0, 1'b0, 1'b0);
    issue(16'hB7FF, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 250; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      r[15:12] = 4'($urandom_range(0, 14));
      issue(r, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset arriving during the EXEC cycle of a store.
    ir = 16'h3E10; n_flag = 1'b0; z_flag = 1'b0; p_flag = 1'b0;
    exp_q.push_back(fetch_vec());
    exp_q.push_back(idle(3'd1));
    tick(2);
    rst = 1'b1;
    exp_q.push_back(with_reset(exec_model(16'h3E10, 1'b0, 1'b0, 1'b0, 1'b0)));
    tick(1);
    rst = 1'b0;
    issue(16'h5A3F, 1'b0, 1'b0, 1'b0);

    // TRAP halts and stays halted until reset.
    ir = 16'hF025;
    exp_q.push_back(fetch_vec());
    exp_q.push_back(idle(3'd1));
    for (int k = 0; k < 20; k++) exp_q.push_back(idle(3'd4));
    tick(22);
    rst = 1'b1;
    exp_q.push_back(with_reset(idle(3'd4)));
    exp_q.push_back(with_reset(idle(3'd0)));
    tick(2);
    rst = 1'b0;
    issue(16'h1262, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Multi-cycle FSM controller for the PUnC LC3 datapath.
- Sequences fetch, decode, execute and a second execute phase for the LC3 subset.
- Drives every select, load and write-enable port of the datapath.
- Consumes the IR and the N/Z/P condition flags returned by the datapath; halts on TRAP.

Parameters:
- START_PC, 16'h0000, PC value loaded (via PC_clr) on reset.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- ir  in  16  instruction register contents from datapath
- n_flag, z_flag, p_flag  in  1 each  condition codes from datapath
- PC_ld, PC_clr, PC_inc  out  1 each  PC load / clear-to-START_PC / increment
- PC_data_sel  out  1  0=adder output, 1=RF r_data_0 (BaseR)
- PC_add_sel  out  1  0=PCoffset11, 1=PCoffset9
- IR_ld  out  1  load IR from memory read data
- addr_MEM_sel  out  2  00=PC, 01=ALU result, 10=store (indirect) register
- w_en_MEM  out  1  memory write enable
- store_ld  out  1  load indirect-address register from memory read data
- w_RF_sel  out  2  00=PC, 01=memory data, 10=ALU result
- r_addr_0_RF, r_addr_1_RF, w_addr_RF  out  3 each  RF port addresses
- w_en_RF  out  1  RF write enable
- sext_sel  out  2  00=imm5, 01=offset6, 10=offset9, 11=offset11
- A_sel  out  1  0=PC, 1=RF r_data_0
- B_sel  out  1  0=RF r_data_1, 1=sign-extended immediate
- ALU_sel  out  2  00=ADD, 01=AND, 10=NOT A, 11=pass A+B (address add)
- NZP_sel  out  1  0=ALU result, 1=memory data
- nzp_ld  out  1  load N/Z/P together
- halted  out  1  high in HALT state
- state_dbg  out  3  current state encoding

Behaviour:
- States (encoding): FETCH=0, DECODE=1, EXEC=2, EXEC2=3, HALT=4.
- Reset (rst high at posedge): state<=FETCH. PC_clr asserted combinationally while rst high. All other outputs in every state default to 0, addresses to 3'b000.
- Outputs are Moore/decoded combinationally from state and ir. The datapath's memory and RF read combinationally and write on posedge.
- FETCH: addr_MEM_sel=00, IR_ld=1, PC_inc=1. Next state DECODE. The IR therefore holds the instruction at PC, and PC holds PC+1 from DECODE onward.
- DECODE: no enables asserted. If ir[15:12]=1111, go to HALT; else EXEC.
- EXEC, by opcode ir[15:12]:
  - ADD 0001 / AND 0101: r_addr_0=ir[8:6], A_sel=1. If ir[5]=1: B_sel=1, sext_sel=00; else r_addr_1=ir[2:0]. ALU_sel=00/01. w_RF_sel=10, w_addr=ir[11:9], w_en_RF=1, NZP_sel=0, nzp_ld=1.
  - NOT 1001: as ADD, with ALU_sel=10.
  - BR 0000: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). If taken: PC_ld=1, PC_data_sel=0, PC_add_sel=1. The nzp=000 encoding is never taken.
  - JMP 1100: r_addr_0=ir[8:6], PC_data_sel=1, PC_ld=1.
  - JSR 0100: w_RF_sel=00, w_addr=7, w_en_RF=1, PC_ld=1. If ir[11]=1: PC_data_sel=0, PC_add_sel=0; else PC_data_sel=1, r_addr_0=ir[8:6]. R7 receives the pre-update PC (same edge). JSRR R7 uses the old R7.
  - LD 0010 / LEA 1110: A_sel=0, B_sel=1, sext_sel=10, ALU_sel=11, w_addr=ir[11:9], w_en_RF=1, nzp_ld=1.
    - LD: addr_MEM_sel=01, w_RF_sel=01, NZP_sel=1.
    - LEA: w_RF_sel=10, NZP_sel=0.
  - LDR 0110: A_sel=1, r_addr_0=ir[8:6], B_sel=1, sext_sel=01, ALU_sel=11, addr_MEM_sel=01, w_RF_sel=01, w_en_RF=1, w_addr=ir[11:9], NZP_sel=1, nzp_ld=1.
  - ST 0011: PC+off9 address, r_addr_1=ir[11:9], w_en_MEM=1.
  - STR 0111: BaseR+off6 address, r_addr_1=ir[11:9], w_en_MEM=1.
  - LDI 1010 / STI 1011: PC+off9 address, store_ld=1. Next state EXEC2.
  - All other opcodes (1000, 1101): no enables (NOP).
  - Next state FETCH, except LDI/STI.
- EXEC2:
  - LDI: addr_MEM_sel=10, w_RF_sel=01, w_en_RF=1, w_addr=ir[11:9], NZP_sel=1, nzp_ld=1.
  - STI: addr_MEM_sel=10, r_addr_1=ir[11:9], w_en_MEM=1.
  - Next state FETCH.
- HALT: all enables 0, halted=1. Remains in HALT until rst.
- Reset mid-instruction: pending writes are suppressed in the reset cycle (w_en_RF, w_en_MEM, PC_ld, IR_ld, nzp_ld forced 0 while rst). The next posedge lands in FETCH with PC=START_PC.
- Never assert w_en_RF and w_en_MEM in the same cycle. Never assert PC_ld and PC_inc in the same cycle.
- Latency: 3 cycles per instruction, 4 for LDI/STI.

Test Plan:
- Reset: hold rst 2 cycles -> state_dbg=0, PC_clr=1, halted=0; first IR_ld pulse on the cycle after rst drops.
- ir=16'h1262 (ADD R1,R1,#2) -> EXEC shows r_addr_0=1, B_sel=1, sext_sel=00, ALU_sel=00, w_addr=1, w_en_RF=1, nzp_ld=1; next state FETCH.
- ir=16'h0A05 (BRnp) with z=1 -> no PC_ld. Same ir with n=1 -> PC_ld=1, PC_add_sel=1, PC_data_sel=0.
- ir=16'hA403 (LDI R2) -> EXEC: store_ld=1, addr_MEM_sel=01. EXEC2: addr_MEM_sel=10, w_addr=2, w_en_RF=1, NZP_sel=1; 4 cycles total.
- ir=16'h4805 (JSR) -> w_addr=7, w_RF_sel=00, PC_ld=1, PC_add_sel=0, in the same cycle. ir=16'h4080 (JSRR R2) -> r_addr_0=2, PC_data_sel=1.
- ir=16'hF025 -> DECODE then HALT, halted=1 held 20 cycles, no enables. rst asserted during EXEC of ST -> w_en_MEM=0 that cycle, then FETCH.
